// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle datapath. Serves MemRead/MemWrite
// requests from the control unit against a synchronous SRAM with WAIT_CYCLES
// extra wait states, registers the returned word, pulses MemReady on
// completion and raises StallReq while an access is in flight.
//
// Optional feature macro: MEM_RESPONDER_FAULT_EN
//   defined   : requests with Addr >= MEM_WORDS, or with MemRead and MemWrite
//               both high, are rejected without touching the SRAM; AddrFault
//               and MemReady pulse together for one cycle.
//   undefined : no checks, AddrFault stays 0, read+write is done as a write.
//
// Parameters:
//   WAIT_CYCLES  extra SRAM wait states per access (0..7)
//   MEM_WORDS    implemented words (range check only)
//
// Ports:
//   CLK, Reset             clock, synchronous active-high reset
//   MemRead, MemWrite      level-sampled requests from the control unit
//   Addr, WriteData        word address (IorD-muxed) and store data
//   ReadData               registered read result
//   MemReady               one-cycle completion pulse
//   StallReq               high while an access is in flight
//   AddrFault              one-cycle fault pulse (fault build only)
//   sram_en, sram_we       SRAM enable / write enable
//   sram_addr, sram_wdata  SRAM address / write data
//   sram_rdata             SRAM read data, valid by end of final access cycle
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MEM_WORDS   = 32'h0000_F000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] Addr,
    input  logic [15:0] WriteData,
    output logic [15:0] ReadData,
    output logic        MemReady,
    output logic        StallReq,
    output logic        AddrFault,
    output logic        sram_en,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        fault_q, fault_d;

    logic        req;
    logic        reject;

    assign req = MemRead | MemWrite;

`ifdef MEM_RESPONDER_FAULT_EN
    assign reject = (32'(Addr) >= MEM_WORDS) || (MemRead && MemWrite);
`else
    assign reject = 1'b0;
`endif

    // State register. Everything here is reset because the reset state of the
    // latches is directly visible on sram_addr / sram_wdata / ReadData.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic, including the request latches and read capture.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path through
        // the case statement can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        fault_d = fault_q;

        unique case (state_q)
            // Requests are accepted both from IDLE and from the completion
            // cycle, which is what makes back-to-back accesses possible.
            ST_IDLE, ST_DONE: begin
                fault_d = 1'b0;
                if (req) begin
                    if (reject) begin
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        addr_d  = Addr;
                        wdata_d = WriteData;
                        we_d    = MemWrite;
                        cnt_d   = 3'(WAIT_CYCLES);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    if (!we_q) begin
                        rdata_d = sram_rdata;
                    end
                    state_d = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only; no request input
    // reaches an output combinationally.
    always_comb begin
        StallReq   = (state_q == ST_ACCESS);
        MemReady   = (state_q == ST_DONE);
        AddrFault  = (state_q == ST_DONE) && fault_q;
        sram_en    = (state_q == ST_ACCESS);
        sram_we    = (state_q == ST_ACCESS) && we_q;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        ReadData   = rdata_q;
    end

endmodule
